// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the MIPS hazard logic: forwarding select encodings
// and the divide-stall FSM state encoding.
package mycpu_defs;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/hazard_unit_div_stall_timer.sv
// Freezes the E stage for DIV_CYCLES cycles while a div/divu is in E, then
// pulses div_doneE for the HI/LO write; excM aborts the window.
module div_stall_timer
    import mycpu_defs::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic divE,
    input  logic excM,
    output logic divstall,
    output logic div_busy,
    output logic div_doneE
);

    // IDLE contributes the first stall cycle, so BUSY covers the remaining DIV_CYCLES-1.
    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 2);

    div_state_t state;
    div_state_t state_next;
    logic [5:0] cnt;
    logic [5:0] cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        divstall   = 1'b0;
        div_doneE  = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (divE) begin
                    divstall   = 1'b1;
                    state_next = DIV_BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            DIV_BUSY: begin
                divstall = 1'b1;
                if (cnt == 6'd0) begin
                    state_next = DIV_DONE;
                end else begin
                    cnt_next = cnt - 6'd1;
                end
            end
            DIV_DONE: begin
                div_doneE  = 1'b1;
                state_next = DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase
        // An exception flushes the divide out of E, so the window is abandoned.
        if (excM) begin
            state_next = DIV_IDLE;
            cnt_next   = '0;
            divstall   = 1'b0;
            div_doneE  = 1'b0;
        end
    end

    assign div_busy = (state != DIV_IDLE);

endmodule

// File: rtl/hazard_unit.sv
// Forwarding selects plus stall/flush generation for the five-stage MIPS
// pipeline; exception flush outranks divide stall, which outranks load/branch stalls.
module hazard_unit
    import mycpu_defs::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       branchD,
    input  logic       jrD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic       regwriteE,
    input  logic       memtoregE,
    input  logic [4:0] writeregM,
    input  logic       regwriteM,
    input  logic       memtoregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteW,
    input  logic       divE,
    input  logic       excM,
    output logic       forwardaD,
    output logic       forwardbD,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic       div_busy,
    output logic       div_doneE
);

    // $0 is hardwired to zero and never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic wr_m,
                                           input logic [4:0] dst_m, input logic wr_w,
                                           input logic [4:0] dst_w);
        if (wr_m && reg_match(dst_m, src)) return FWD_MEM;
        if (wr_w && reg_match(dst_w, src)) return FWD_WB;
        return FWD_RF;
    endfunction

    logic divstall;
    logic lwstall;
    logic brstall;
    logic haz_rs;
    logic haz_rt;

    div_stall_timer #(.DIV_CYCLES(DIV_CYCLES)) u_div_timer (
        .clk       (clk),
        .rst       (rst),
        .divE      (divE),
        .excM      (excM),
        .divstall  (divstall),
        .div_busy  (div_busy),
        .div_doneE (div_doneE)
    );

    assign forwardaE = fwd_sel(rsE, regwriteM, writeregM, regwriteW, writeregW);
    assign forwardbE = fwd_sel(rtE, regwriteM, writeregM, regwriteW, writeregW);
    assign forwardaD = regwriteM && reg_match(writeregM, rsD);
    assign forwardbD = regwriteM && reg_match(writeregM, rtD);

    assign lwstall = memtoregE && (reg_match(writeregE, rsD) || reg_match(writeregE, rtD));
    // Branch operands are compared in D, so an ALU result still in E or a load in M cannot be forwarded.
    assign haz_rs  = (regwriteE && reg_match(writeregE, rsD)) || (memtoregM && reg_match(writeregM, rsD));
    assign haz_rt  = (regwriteE && reg_match(writeregE, rtD)) || (memtoregM && reg_match(writeregM, rtD));
    assign brstall = (branchD && (haz_rs || haz_rt)) || (jrD && haz_rs);

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (excM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else if (divstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwstall || brstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_hazard_unit;

    localparam int NDIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       branchD, jrD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW;
    logic       divE, excM;
    logic       forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic       stallF, stallD, stallE, flushD, flushE, flushM, flushW;
    logic       div_busy, div_doneE;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    hazard_unit #(.DIV_CYCLES(NDIV)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .writeregM(writeregM), .regwriteM(regwriteM),
        .memtoregM(memtoregM), .writeregW(writeregW), .regwriteW(regwriteW),
        .divE(divE), .excM(excM), .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE), .stallF(stallF), .stallD(stallD),
        .stallE(stallE), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .flushW(flushW), .div_busy(div_busy), .div_doneE(div_doneE)
    );

    // Packing: {faE, fbE, faD, fbD, stall F/D/E, flush D/E/M/W, busy, done}
    function automatic logic [14:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic fad, input logic fbd,
                                       input logic [2:0] stl, input logic [3:0] fl,
                                       input logic busy, input logic done);
        return {fa, fb, fad, fbd, stl, fl, busy, done};
    endfunction

    wire [14:0] act = {forwardaE, forwardbE, forwardaD, forwardbD, stallF, stallD, stallE,
                       flushD, flushE, flushM, flushW, div_busy, div_doneE};

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            checks++;
            if (act !== it.exp) begin
                failures++;
                $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
            end
        end
    end

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
        branchD = 0; jrD = 0; regwriteE = 0; memtoregE = 0; regwriteM = 0; memtoregM = 0;
        regwriteW = 0; divE = 0; excM = 0;
    endtask

    task automatic cyc(input string nm, input logic [14:0] e);
        item_t it;
        it.name = nm;
        it.exp  = e;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    localparam logic [14:0] ZERO   = 15'd0;
    localparam logic [2:0]  ST_FD  = 3'b110;
    localparam logic [2:0]  ST_FDE = 3'b111;
    localparam logic [3:0]  FL_E   = 4'b0100;
    localparam logic [3:0]  FL_M   = 4'b0010;
    localparam logic [3:0]  FL_ALL = 4'b1111;

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        cyc("reset_state", ZERO);
        rst = 1'b0;
        cyc("idle_after_reset", ZERO);

        // Forwarding priority
        regwriteM = 1; writeregM = 8; regwriteW = 1; writeregW = 8; rsE = 8;
        cyc("fwdA_mem", mk(2'b10, 2'b00, 0, 0, 3'b0, 4'b0, 0, 0));
        regwriteM = 0;
        cyc("fwdA_wb", mk(2'b01, 2'b00, 0, 0, 3'b0, 4'b0, 0, 0));
        regwriteM = 1; writeregM = 0; writeregW = 0; rsE = 0;
        cyc("fwdA_r0", ZERO);
        writeregM = 8; rsD = 8; rtD = 8; rtE = 8; regwriteW = 0;
        cyc("fwdD_both_fwdB_mem", mk(2'b00, 2'b10, 1, 1, 3'b0, 4'b0, 0, 0));
        clear_inputs();

        // Load-use
        memtoregE = 1; writeregE = 9; rtD = 9;
        cyc("lwstall_rt", mk(2'b00, 2'b00, 0, 0, ST_FD, FL_E, 0, 0));
        writeregE = 0;
        cyc("lwstall_r0", ZERO);
        clear_inputs();

        // Branch / jr hazards
        branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
        cyc("brstall_rs_E", mk(2'b00, 2'b00, 0, 0, ST_FD, FL_E, 0, 0));
        branchD = 0; jrD = 1; rsD = 0; rtD = 4;
        cyc("jr_rt_nostall", ZERO);
        clear_inputs();
        branchD = 1; rtD = 5; memtoregM = 1; writeregM = 5;
        cyc("brstall_rt_loadM", mk(2'b00, 2'b00, 0, 0, ST_FD, FL_E, 0, 0));
        clear_inputs();

        // Exception outranks load-use
        excM = 1; memtoregE = 1; writeregE = 9; rsD = 9;
        cyc("exc_over_lw", mk(2'b00, 2'b00, 0, 0, 3'b0, FL_ALL, 0, 0));
        clear_inputs();

        // Full divide window, divE held through the done pulse
        divE = 1;
        cyc("div_c0", mk(2'b00, 2'b00, 0, 0, ST_FDE, FL_M, 0, 0));
        for (int i = 1; i < NDIV; i++) cyc($sformatf("div_c%0d", i), mk(2'b00, 2'b00, 0, 0, ST_FDE, FL_M, 1, 0));
        cyc("div_done", mk(2'b00, 2'b00, 0, 0, 3'b0, 4'b0, 1, 1));
        divE = 0;
        cyc("div_idle_after", ZERO);

        // Divide coinciding with load-use: divide pattern wins, no flushE
        divE = 1; memtoregE = 1; writeregE = 9; rtD = 9;
        cyc("div_over_lw_c0", mk(2'b00, 2'b00, 0, 0, ST_FDE, FL_M, 0, 0));
        cyc("div_over_lw_c1", mk(2'b00, 2'b00, 0, 0, ST_FDE, FL_M, 1, 0));
        clear_inputs();
        divE = 1;
        for (int i = 2; i < NDIV; i++) cyc($sformatf("div2_c%0d", i), mk(2'b00, 2'b00, 0, 0, ST_FDE, FL_M, 1, 0));
        cyc("div2_done", mk(2'b00, 2'b00, 0, 0, 3'b0, 4'b0, 1, 1));
        divE = 0;
        cyc("div2_idle", ZERO);

        // Divide aborted by exception while BUSY
        divE = 1;
        cyc("abort_c0", mk(2'b00, 2'b00, 0, 0, ST_FDE, FL_M, 0, 0));
        cyc("abort_c1", mk(2'b00, 2'b00, 0, 0, ST_FDE, FL_M, 1, 0));
        excM = 1;
        cyc("abort_exc", mk(2'b00, 2'b00, 0, 0, 3'b0, FL_ALL, 1, 0));
        excM = 0; divE = 0;
        for (int i = 0; i < NDIV; i++) cyc($sformatf("abort_quiet%0d", i), ZERO);

        // Asynchronous reset mid-divide
        divE = 1;
        cyc("rstdiv_c0", mk(2'b00, 2'b00, 0, 0, ST_FDE, FL_M, 0, 0));
        divE = 0;
        cyc("rstdiv_c1", mk(2'b00, 2'b00, 0, 0, ST_FDE, FL_M, 1, 0));
        rst = 1'b1;
        cyc("rst_async_busy_drop", ZERO);
        rst = 1'b0;
        cyc("after_rst0", ZERO);
        cyc("after_rst1", ZERO);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d pending expected 0", sb.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
